// File: rtl/vx_writeback_banked_pkg.sv
// Shared types for the banked writeback arbiter.
//   wb_pkt_t    : one writeback packet (warp id, pc, thread mask, rd, per-thread data, eop)
//   WB_PKT_W    : packed width of wb_pkt_t
//   wb_bank_sel : GPR bank owning a warp id (low bank bits of wid; 0 for a single bank)
package vx_writeback_banked_pkg;
  localparam int NW_WIDTH    = 2;
  localparam int NUM_THREADS = 2;
  localparam int XLEN        = 32;
  localparam int NR_BITS     = 5;

  typedef struct packed {
    logic [NW_WIDTH-1:0]                wid;
    logic [XLEN-1:0]                    pc;
    logic [NUM_THREADS-1:0]             tmask;
    logic [NR_BITS-1:0]                 rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]   data;
    logic                               eop;
  } wb_pkt_t;

  localparam int WB_PKT_W = $bits(wb_pkt_t);

  // num_banks is a power of two, so masking by num_banks-1 keeps the low bank bits
  // and collapses to 0 when there is a single bank.
  function automatic logic [NW_WIDTH-1:0] wb_bank_sel(input logic [NW_WIDTH-1:0] wid,
                                                      input int num_banks);
    return wid & NW_WIDTH'(num_banks - 1);
  endfunction
endpackage

// File: rtl/vx_writeback_banked_if.sv
// Commit-side and writeback-side bus of the banked writeback arbiter.
//   commit_valid/commit_wb/commit_pkt -> commit_ready  : NUM_INPUTS commit channels
//   wb_valid/wb_pkt <- wb_ready                        : NUM_BANKS GPR bank ports
//   perf_stalls                                        : per-bank conflict-stall counters
// master = commit producer + GPR sink, slave = the arbiter.
interface vx_writeback_banked_if
  import vx_writeback_banked_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int NUM_BANKS  = 2,
  parameter int PERF_W     = 32
);
  logic    [NUM_INPUTS-1:0]             commit_valid;
  logic    [NUM_INPUTS-1:0]             commit_wb;
  wb_pkt_t [NUM_INPUTS-1:0]             commit_pkt;
  logic    [NUM_INPUTS-1:0]             commit_ready;
  logic    [NUM_BANKS-1:0]              wb_valid;
  wb_pkt_t [NUM_BANKS-1:0]              wb_pkt;
  logic    [NUM_BANKS-1:0]              wb_ready;
  logic    [NUM_BANKS-1:0][PERF_W-1:0]  perf_stalls;

  modport master (
    output commit_valid, commit_wb, commit_pkt, wb_ready,
    input  commit_ready, wb_valid, wb_pkt, perf_stalls
  );
  modport slave (
    input  commit_valid, commit_wb, commit_pkt, wb_ready,
    output commit_ready, wb_valid, wb_pkt, perf_stalls
  );
endinterface

// File: rtl/vx_writeback_banked_bank.sv
// One GPR bank of the writeback arbiter.
//   req/pkt_in   : per-input request mask for this bank and all input packets
//   fire         : one-hot grant that actually pushes this cycle (0 when full)
//   valid/pkt    : registered writeback output, ready = bank accepts
//   stalls       : cycles with >1 requester, or >=1 requester while full
// Storage is an output register plus one skid register, i.e. a 2-entry elastic
// buffer whose full flag is registered, so grants never depend on same-cycle ready.
module vx_writeback_banked_bank
  import vx_writeback_banked_pkg::*;
#(
  parameter int    NUM_INPUTS = 5,
  parameter string ARBITER    = "R",
  parameter int    PERF_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic    [NUM_INPUTS-1:0]   req,
  input  wb_pkt_t [NUM_INPUTS-1:0]   pkt_in,
  output logic    [NUM_INPUTS-1:0]   fire,
  output logic                       valid,
  output wb_pkt_t                    pkt,
  input  logic                       ready,
  output logic    [PERF_W-1:0]       stalls
);
  localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [PTR_W-1:0] ptr, win_idx;
  logic             any_req, full, push, pop, skid_vld, stall;
  wb_pkt_t          skid, push_pkt;
  int               idx, nreq;

  // Scan from the round-robin pointer (or from input 0 for fixed priority);
  // first requester found wins.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    idx     = 0;
    nreq    = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = (ARBITER == "P") ? k : (int'(ptr) + k) % NUM_INPUTS;
      if (req[idx] && !any_req) begin
        any_req = 1'b1;
        win_idx = PTR_W'(idx);
      end
      if (req[k]) nreq++;
    end
  end

  assign full     = valid && skid_vld;
  assign push     = any_req && !full;
  assign pop      = valid && ready;
  assign push_pkt = pkt_in[win_idx];
  assign stall    = (nreq > 1) || (any_req && full);

  always_comb begin
    fire = '0;
    if (push) fire[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      pkt      <= '0;
      skid_vld <= 1'b0;
      skid     <= '0;
      ptr      <= '0;
      stalls   <= '0;
    end else begin
      // Output slot frees up: refill from skid first to keep grant order,
      // otherwise take this cycle's push directly.
      if (pop || !valid) begin
        if (skid_vld) begin
          valid    <= 1'b1;
          pkt      <= skid;
          skid_vld <= 1'b0;
        end else begin
          valid <= push;
          if (push) pkt <= push_pkt;
        end
      end else if (push) begin
        skid_vld <= 1'b1;
        skid     <= push_pkt;
      end
      if (push && ARBITER != "P")
        ptr <= (win_idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : win_idx + PTR_W'(1);
      if (stall) stalls <= stalls + PERF_W'(1);
    end
  end
endmodule

// File: rtl/vx_writeback_banked.sv
// Banked writeback arbiter: merges NUM_INPUTS commit streams onto NUM_BANKS
// independent GPR writeback ports, bank = wid % NUM_BANKS.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of vx_writeback_banked_if (commit in, writeback out, perf)
// Commits with wb=0 are acknowledged immediately and never use a bank.
module vx_writeback_banked
  import vx_writeback_banked_pkg::*;
#(
  parameter int    NUM_INPUTS = 5,
  parameter int    NUM_BANKS  = 2,
  parameter string ARBITER    = "R",
  parameter int    PERF_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_writeback_banked_if.slave   bus
);
  logic [NUM_BANKS-1:0][NUM_INPUTS-1:0] req, fire;
  logic [NUM_INPUTS-1:0]                fire_any;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_req
      assign req[b][i] = bus.commit_valid[i] && bus.commit_wb[i] &&
                         (wb_bank_sel(bus.commit_pkt[i].wid, NUM_BANKS) == NW_WIDTH'(b));
    end

    vx_writeback_banked_bank #(
      .NUM_INPUTS (NUM_INPUTS),
      .ARBITER    (ARBITER),
      .PERF_W     (PERF_W)
    ) u_bank (
      .clk    (clk),
      .reset  (reset),
      .req    (req[b]),
      .pkt_in (bus.commit_pkt),
      .fire   (fire[b]),
      .valid  (bus.wb_valid[b]),
      .pkt    (bus.wb_pkt[b]),
      .ready  (bus.wb_ready[b]),
      .stalls (bus.perf_stalls[b])
    );
  end

  // An input targets exactly one bank, so OR-ing the per-bank grants is safe.
  always_comb begin
    fire_any = '0;
    for (int b = 0; b < NUM_BANKS; b++) fire_any |= fire[b];
  end

  assign bus.commit_ready = fire_any | (bus.commit_valid & ~bus.commit_wb);
endmodule

// File: tb/tb_vx_writeback_banked.sv
module tb_vx_writeback_banked;
  import vx_writeback_banked_pkg::*;

  localparam int NI = 5;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_writeback_banked_if #(.NUM_INPUTS(NI), .NUM_BANKS(NB), .PERF_W(32)) bus ();
  vx_writeback_banked_if #(.NUM_INPUTS(NI), .NUM_BANKS(NB), .PERF_W(32)) bus_p ();

  vx_writeback_banked #(.NUM_INPUTS(NI), .NUM_BANKS(NB), .ARBITER("R"), .PERF_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  vx_writeback_banked #(.NUM_INPUTS(NI), .NUM_BANKS(NB), .ARBITER("P"), .PERF_W(32)) dut_p (
    .clk(clk), .reset(reset), .bus(bus_p));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per-bank FIFO of packets in flight (max 2), RR pointer, stall count.
  wb_pkt_t     mq [NB][$];
  int          mptr [NB];
  logic [31:0] mperf [NB];
  logic [NI-1:0] exp_ready;
  int          exp_win [NB];
  logic        exp_stall [NB];

  function automatic wb_pkt_t rand_pkt(input int wid);
    wb_pkt_t p;
    p.wid   = wid[NW_WIDTH-1:0];
    p.pc    = $urandom;
    p.tmask = NUM_THREADS'($urandom);
    p.rd    = NR_BITS'($urandom);
    for (int t = 0; t < NUM_THREADS; t++) p.data[t] = $urandom;
    p.eop   = 1'($urandom);
    return p;
  endfunction

  task automatic set_idle();
    bus.commit_valid = '0;  bus.commit_wb = '0;  bus.commit_pkt = '0;  bus.wb_ready = '1;
    bus_p.commit_valid = '0; bus_p.commit_wb = '0; bus_p.commit_pkt = '0; bus_p.wb_ready = '1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      mq[b].delete();
      mptr[b]  = 0;
      mperf[b] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic model_predict();
    int nreq, i;
    logic full;
    for (int b = 0; b < NB; b++) begin
      exp_win[b] = -1;
      nreq = 0;
      full = (mq[b].size() == 2);
      for (int k = 0; k < NI; k++) begin
        i = (mptr[b] + k) % NI;
        if (bus.commit_valid[i] && bus.commit_wb[i] && (int'(bus.commit_pkt[i].wid) % NB == b)) begin
          nreq++;
          if (exp_win[b] < 0) exp_win[b] = i;
        end
      end
      exp_stall[b] = (nreq > 1) || (nreq > 0 && full);
      if (full) exp_win[b] = -1;
    end
    exp_ready = '0;
    for (int k = 0; k < NI; k++)
      if (bus.commit_valid[k] && !bus.commit_wb[k]) exp_ready[k] = 1'b1;
    for (int b = 0; b < NB; b++)
      if (exp_win[b] >= 0) exp_ready[exp_win[b]] = 1'b1;
  endtask

  task automatic model_commit();
    for (int b = 0; b < NB; b++) begin
      if (mq[b].size() > 0 && bus.wb_ready[b]) void'(mq[b].pop_front());
      if (exp_win[b] >= 0) begin
        mq[b].push_back(bus.commit_pkt[exp_win[b]]);
        mptr[b] = (exp_win[b] + 1) % NI;
      end
      if (exp_stall[b]) mperf[b] = mperf[b] + 1;
    end
  endtask

  task automatic test_reset();
    wb_pkt_t p;
    do_reset();
    n_cmp++; if (bus.wb_valid !== '0) begin n_err++; $display("FAIL reset_valid got %b exp 00", bus.wb_valid); end
    n_cmp++; if (bus.wb_pkt !== '0) begin n_err++; $display("FAIL reset_data got %h exp 0", bus.wb_pkt); end
    n_cmp++; if (bus.perf_stalls !== '0) begin n_err++; $display("FAIL reset_perf got %h exp 0", bus.perf_stalls); end
    // fill bank0 with wb_ready low, then hit reset mid-cycle
    p = rand_pkt(0);
    bus.commit_valid[0] = 1'b1; bus.commit_wb[0] = 1'b1; bus.commit_pkt[0] = p; bus.wb_ready = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (bus.commit_ready[0] !== (c < 2)) begin n_err++; $display("FAIL fill_ready c=%0d got %b exp %b", c, bus.commit_ready[0], c < 2); end
      @(negedge clk);
    end
    n_cmp++; if (bus.perf_stalls[0] !== 32'd1) begin n_err++; $display("FAIL fill_perf got %0d exp 1", bus.perf_stalls[0]); end
    n_cmp++; if (bus.wb_valid[0] !== 1'b1) begin n_err++; $display("FAIL fill_valid got %b exp 1", bus.wb_valid[0]); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.wb_valid !== '0) begin n_err++; $display("FAIL async_valid got %b exp 00", bus.wb_valid); end
    n_cmp++; if (bus.perf_stalls !== '0) begin n_err++; $display("FAIL async_perf got %h exp 0", bus.perf_stalls); end
    set_idle();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    p = rand_pkt(2);
    bus.commit_valid[0] = 1'b1; bus.commit_wb[0] = 1'b1; bus.commit_pkt[0] = p;
    #1;
    n_cmp++; if (bus.wb_valid[0] !== 1'b0 || bus.commit_ready[0] !== 1'b1) begin n_err++;
      $display("FAIL post_reset_fire got valid=%b ready=%b exp valid=0 ready=1", bus.wb_valid[0], bus.commit_ready[0]); end
    @(negedge clk);
    set_idle();
    #1;
    n_cmp++; if (bus.wb_valid[0] !== 1'b1 || bus.wb_pkt[0] !== p) begin n_err++;
      $display("FAIL post_reset_out got valid=%b pkt=%h exp 1 %h", bus.wb_valid[0], bus.wb_pkt[0], p); end
    @(negedge clk);
  endtask

  task automatic test_bank_parallel();
    wb_pkt_t p0, p1;
    for (int w = 0; w < 4; w += 2) begin
      do_reset();
      p0 = rand_pkt(w); p1 = rand_pkt(w + 1);
      bus.commit_valid[1:0] = 2'b11; bus.commit_wb[1:0] = 2'b11;
      bus.commit_pkt[0] = p0; bus.commit_pkt[1] = p1;
      #1;
      n_cmp++; if (bus.commit_ready !== 5'b00011) begin n_err++; $display("FAIL par_ready w=%0d got %b exp 00011", w, bus.commit_ready); end
      @(negedge clk);
      set_idle();
      #1;
      n_cmp++; if (bus.wb_valid !== 2'b11) begin n_err++; $display("FAIL par_valid w=%0d got %b exp 11", w, bus.wb_valid); end
      n_cmp++; if (bus.wb_pkt[0] !== p0 || bus.wb_pkt[1] !== p1) begin n_err++;
        $display("FAIL par_data w=%0d got %h/%h exp %h/%h", w, bus.wb_pkt[0], bus.wb_pkt[1], p0, p1); end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_fairness();
    wb_pkt_t prev, cur;
    logic [NI-1:0] exp;
    do_reset();
    bus.commit_valid = '1; bus.commit_wb = '1;
    prev = '0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NI; i++) bus.commit_pkt[i] = rand_pkt(2);
      #1;
      exp = NI'(1) << (c % NI);
      n_cmp++; if (bus.commit_ready !== exp) begin n_err++; $display("FAIL rr_grant c=%0d got %b exp %b", c, bus.commit_ready, exp); end
      if (c > 0) begin
        n_cmp++; if (bus.wb_valid[0] !== 1'b1 || bus.wb_pkt[0] !== prev) begin n_err++;
          $display("FAIL rr_out c=%0d got %h exp %h", c, bus.wb_pkt[0], prev); end
      end
      cur = bus.commit_pkt[c % NI];
      prev = cur;
      @(negedge clk);
    end
    set_idle();
    #1;
    n_cmp++; if (bus.perf_stalls[0] !== 32'd10) begin n_err++; $display("FAIL rr_perf got %0d exp 10", bus.perf_stalls[0]); end
    n_cmp++; if (bus.wb_pkt[0] !== prev) begin n_err++; $display("FAIL rr_last got %h exp %h", bus.wb_pkt[0], prev); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    wb_pkt_t acc[$];
    wb_pkt_t p;
    int drained;
    do_reset();
    bus.wb_ready = 2'b10;
    p = rand_pkt(0);
    bus.commit_valid[0] = 1'b1; bus.commit_wb[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.commit_pkt[0] = p;
      #1;
      if (c >= 2) begin
        n_cmp++; if (bus.commit_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_ready c=%0d got %b exp 0", c, bus.commit_ready[0]); end
      end
      if (c >= 1) begin
        n_cmp++; if (bus.wb_valid[0] !== 1'b1 || bus.wb_pkt[0] !== acc[0]) begin n_err++;
          $display("FAIL bp_stable c=%0d got %h exp %h", c, bus.wb_pkt[0], acc[0]); end
      end
      if (bus.commit_ready[0]) begin acc.push_back(p); p = rand_pkt(0); end
      @(negedge clk);
    end
    n_cmp++; if (acc.size() != 2) begin n_err++; $display("FAIL bp_accepted got %0d exp 2", acc.size()); end
    set_idle();
    drained = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.wb_valid[0]) begin
        drained++;
        n_cmp++; if (acc.size() == 0 || bus.wb_pkt[0] !== acc[0]) begin n_err++;
          $display("FAIL bp_drain c=%0d got %h", c, bus.wb_pkt[0]); end
        if (acc.size() > 0) void'(acc.pop_front());
      end
      @(negedge clk);
    end
    n_cmp++; if (drained != 2) begin n_err++; $display("FAIL bp_drain_count got %0d exp 2", drained); end
  endtask

  task automatic test_bypass();
    int seen;
    do_reset();
    bus.wb_ready = 2'b10;
    bus.commit_valid[0] = 1'b1; bus.commit_wb[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.commit_pkt[0] = rand_pkt(0);
      @(negedge clk);
    end
    bus.commit_valid[0] = 1'b0;
    bus.commit_valid[3] = 1'b1; bus.commit_wb[3] = 1'b0; bus.commit_pkt[3] = rand_pkt(0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (bus.commit_ready !== 5'b01000) begin n_err++; $display("FAIL byp_ready c=%0d got %b exp 01000", c, bus.commit_ready); end
      @(negedge clk);
    end
    bus.wb_ready = 2'b11;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.wb_valid[0]) seen++;
      n_cmp++; if (bus.wb_valid[1] !== 1'b0) begin n_err++; $display("FAIL byp_bank1 c=%0d got %b exp 0", c, bus.wb_valid[1]); end
      @(negedge clk);
    end
    n_cmp++; if (seen != 2) begin n_err++; $display("FAIL byp_outputs got %0d exp 2", seen); end
    set_idle();
  endtask

  task automatic test_priority();
    wb_pkt_t prev;
    do_reset();
    bus_p.commit_valid[1] = 1'b1; bus_p.commit_wb[1] = 1'b1;
    bus_p.commit_valid[4] = 1'b1; bus_p.commit_wb[4] = 1'b1;
    prev = '0;
    for (int c = 0; c < 8; c++) begin
      bus_p.commit_pkt[1] = rand_pkt((c % 2) ? 3 : 1);
      bus_p.commit_pkt[4] = rand_pkt(1);
      #1;
      n_cmp++; if (bus_p.commit_ready !== 5'b00010) begin n_err++; $display("FAIL prio_ready c=%0d got %b exp 00010", c, bus_p.commit_ready); end
      if (c > 0) begin
        n_cmp++; if (bus_p.wb_valid[1] !== 1'b1 || bus_p.wb_pkt[1] !== prev) begin n_err++;
          $display("FAIL prio_out c=%0d got %h exp %h", c, bus_p.wb_pkt[1], prev); end
      end
      prev = bus_p.commit_pkt[1];
      @(negedge clk);
    end
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        bus.commit_valid[i] = ($urandom_range(0, 3) != 0);
        bus.commit_wb[i]    = ($urandom_range(0, 4) != 0);
        bus.commit_pkt[i]   = rand_pkt($urandom_range(0, 3));
      end
      for (int b = 0; b < NB; b++) bus.wb_ready[b] = ($urandom_range(0, 2) != 0);
      #1;
      model_predict();
      n_cmp++; if (bus.commit_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, bus.commit_ready, exp_ready); end
      for (int b = 0; b < NB; b++) begin
        n_cmp++; if (bus.wb_valid[b] !== (mq[b].size() != 0)) begin n_err++;
          $display("FAIL rnd_valid c=%0d b=%0d got %b exp %b", c, b, bus.wb_valid[b], mq[b].size() != 0); end
        if (mq[b].size() != 0) begin
          n_cmp++; if (bus.wb_pkt[b] !== mq[b][0]) begin n_err++;
            $display("FAIL rnd_data c=%0d b=%0d got %h exp %h", c, b, bus.wb_pkt[b], mq[b][0]); end
        end
        n_cmp++; if (bus.perf_stalls[b] !== mperf[b]) begin n_err++;
          $display("FAIL rnd_perf c=%0d b=%0d got %0d exp %0d", c, b, bus.perf_stalls[b], mperf[b]); end
      end
      model_commit();
      @(negedge clk);
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_bank_parallel();
    test_rr_fairness();
    test_backpressure();
    test_bypass();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
